sfr_access_bridge: RTL and testbench
====================================

Name: sfr_access_bridge

Overview:
- Upstream feeder for the shape processor SFR interface.
- Accepts register-access requests on a valid/ready channel and buffers them in a small FIFO.
- Serialises each request into a single-cycle write or read strobe on the SFR port, then samples read_data/error after a fixed latency.
- Returns one response per request on a valid/ready response channel.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >= 2
READ_LATENCY, 1, cycles from read/write strobe to the cycle in which read_data and error are sampled; >= 1

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request
req_write  input  1  1 = write, 0 = read
req_data  input  32  write payload; ignored for reads
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  read data; 0 for writes
rsp_error  output  1  SFR error flag sampled for this access
write  output  1  SFR write strobe
write_data  output  32  SFR write payload
read  output  1  SFR read strobe
read_data  input  32  SFR read data
error  input  1  SFR error flag
fifo_level  output  $clog2(DEPTH+1)  number of entries currently in the FIFO

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - write, read, write_data, rsp_valid, rsp_data, rsp_error, fifo_level = 0.
  - FSM = IDLE, FIFO empty.
  - req_ready = 1 (combinational, equals !full).
- FIFO:
  - Push on req_valid && req_ready.
  - req_ready = (fifo_level != DEPTH); no push-while-full bypass, even on a simultaneous pop.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - req_valid while full is not lost: the source holds its request until req_ready.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, pop the head and go to ISSUE. Else stay.
  - ISSUE (exactly 1 cycle, registered strobes):
    - write=1 with write_data=entry data if the entry is a write; else read=1.
    - write_data = 0 in every cycle other than a write ISSUE.
    - Never write and read high together.
    - Next state is WAIT.
  - WAIT:
    - Count READ_LATENCY cycles starting with the ISSUE cycle as count 1, so READ_LATENCY=1 means sampling in the cycle after ISSUE.
    - In the sample cycle, capture rsp_error <= error and rsp_data <= (read ? read_data : 0).
    - Then go to RESP with rsp_valid=1.
  - RESP:
    - rsp_valid, rsp_data and rsp_error are held stable until rsp_ready.
    - On handshake, rsp_valid=0 next cycle. If the FIFO is non-empty, pop and go directly to ISSUE; else go to IDLE.
- Timing:
  - Latency, empty bridge: request handshake in cycle T → strobe in T+2 → sample in T+1+READ_LATENCY+1 → rsp_valid from T+3+READ_LATENCY.
  - Back-to-back throughput: one access per READ_LATENCY+2 cycles with rsp_ready held high.
- Ordering: strictly in order, one outstanding SFR access at a time; responses match request order.
- rsp_ready while rsp_valid=0 is ignored.
- Capacity: with responses stalled, the bridge absorbs DEPTH+1 requests (one in the FSM, DEPTH in the FIFO) before req_ready falls.
- Reset mid-operation:
  - Immediate return to reset values.
  - Any strobe drops asynchronously.
  - The in-flight access and all queued entries are discarded; no response is produced for them.

Test Plan:
- Single write: req_write=1, req_data=0x0003_0015 → write=1 for exactly one cycle with write_data=0x0003_0015, read=0; then response rsp_data=0, rsp_error=0.
- Single read: req_write=0, read_data=0x0001_0007 driven in the sample cycle → read=1 for one cycle; response rsp_data=0x0001_0007.
- Error path: read with error=1 in the sample cycle only → rsp_error=1. The following write with error=0 → rsp_error=0.
- Backpressure/fill (DEPTH=4): rsp_ready=0, push 6 requests continuously → 5 accepted, req_ready=0, fifo_level=4, first response held stable for 10 cycles. Then rsp_ready=1 → all 5 responses return in order, with req_ready rising after the first pop.
- Back-to-back throughput (READ_LATENCY=1): 3 writes 0xA, 0xB, 0xC with rsp_ready=1 → strobes exactly 3 cycles apart, write_data 0xA, 0xB, 0xC.
- Reset mid-WAIT: assert rst_n=0 in the WAIT cycle with 2 entries queued → write/read/rsp_valid=0 immediately, fifo_level=0, and no response after reset is released.

Source files
------------

// File: rtl/sfr_access_bridge.sv
// sfr_access_bridge: buffers register-access requests in a FIFO and issues
// them one at a time as single-cycle SFR strobes, returning one response each.
module sfr_access_bridge #(
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [31:0]                req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_data,
  output logic                       rsp_error,
  output logic                       write,
  output logic [31:0]                write_data,
  output logic                       read,
  input  logic [31:0]                read_data,
  input  logic                       error,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(READ_LATENCY+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [32:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           op_write_q, op_write_d;
  logic           write_q, write_d, read_q, read_d;
  logic [31:0]    write_data_q, write_data_d;
  logic           rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           push, pop, empty;
  logic [32:0]    head;

  assign req_ready  = level_q != LW'(DEPTH);
  assign empty      = level_q == '0;
  assign push       = req_valid && req_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign write      = write_q;
  assign read       = read_q;
  assign write_data = write_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rsp_error_q;

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    cnt_d        = cnt_q;
    op_write_d   = op_write_q;
    write_d      = 1'b0;
    read_d       = 1'b0;
    write_data_d = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    case (state_q)
      IDLE:  pop = !empty;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(1);
      end
      WAIT:  if (cnt_q == CW'(READ_LATENCY)) begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = error;
        rsp_data_d  = op_write_q ? '0 : read_data;
      end else cnt_d = cnt_q + CW'(1);
      RESP:  if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        pop         = !empty;
        state_d     = IDLE;
      end
    endcase
    // A pop always launches the strobe for the head entry in the next cycle.
    if (pop) begin
      state_d      = ISSUE;
      op_write_d   = head[32];
      write_d      = head[32];
      read_d       = !head[32];
      write_data_d = head[32] ? head[31:0] : '0;
    end
  end

  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= {req_write, req_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      op_write_q   <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      write_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_write_q   <= op_write_d;
      write_q      <= write_d;
      read_q       <= read_d;
      write_data_q <= write_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end
endmodule

// File: tb/tb_sfr_access_bridge.sv
// tb_sfr_access_bridge: directed vectors plus hand-written sequences for
// fill/backpressure, throughput and mid-access reset.
module tb_sfr_access_bridge;
  localparam int DEPTH = 4;
  localparam int RL    = 1;

  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_data = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_error;
  logic [31:0] rsp_data;
  logic        write, read, error = 0;
  logic [31:0] write_data, read_data = 0;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;

  sfr_access_bridge #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .write(write), .write_data(write_data), .read(read), .read_data(read_data), .error(error),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          rsp_n = 0;
  logic        both_seen = 0;
  logic [31:0] wq[$];
  int          wc[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (write) begin
      wq.push_back(write_data);
      wc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) rsp_n <= rsp_n + 1;
    if (write && read) both_seen <= 1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // One request on an idle bridge; read_data/error are valid only in the sample cycle.
  task automatic txn(input vec_t v);
    req_valid = 1; req_write = v.wr; req_data = v.data;
    chk("req_ready idle", req_ready, 1);
    tick;
    req_valid = 0; req_write = 0; req_data = 0;
    chk("no strobe T+1", {write, read}, 0);
    tick;
    chk("write strobe", write, v.wr);
    chk("read strobe", read, !v.wr);
    chk("write_data", write_data, v.wr ? v.data : 32'h0);
    read_data = 32'hDEADBEEF; error = !v.err;
    tick;
    chk("strobe one cycle", {write, read}, 0);
    chk("rsp not early", rsp_valid, 0);
    read_data = v.rdata; error = v.err;
    tick;
    read_data = 32'hBEEFDEAD; error = !v.err;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_error", rsp_error, v.exp_err);
    rsp_ready = 1;
    tick;
    rsp_ready = 0; read_data = 0; error = 0;
    chk("rsp_valid drop", rsp_valid, 0);
  endtask

  initial begin
    int acc, base, rbase;
    logic ok;
    vecs[0] = '{1'b1, 32'h0003_0015, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_0000, 32'h0001_0007, 1'b0, 32'h0001_0007, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 32'h0BAD_0001, 1'b1, 32'h0BAD_0001, 1'b1};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h0000_0009, 1'b0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'hCAFE_F00D, 32'h0, 1'b1, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};

    tick; tick;
    chk("reset write", write, 0);
    chk("reset read", read, 0);
    chk("reset write_data", write_data, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_error", rsp_error, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset req_ready", req_ready, 1);
    rst_n = 1;
    tick;

    foreach (vecs[i]) txn(vecs[i]);

    // Fill with responses stalled: DEPTH+1 accepted.
    base = wq.size(); rbase = rsp_n; acc = 0;
    req_valid = 1; req_write = 1;
    for (int c = 0; c < 8; c++) begin
      req_data = 32'h100 + acc;
      ok = req_ready;
      tick;
      if (ok) acc++;
    end
    req_valid = 0;
    chk("fill accepted", acc, 5);
    chk("fill req_ready", req_ready, 0);
    chk("fill fifo_level", fifo_level, 4);
    for (int c = 0; c < 10; c++) begin
      chk("held rsp_valid", rsp_valid, 1);
      chk("held rsp_data", rsp_data, 0);
      chk("held no strobe", write, 0);
      tick;
    end
    rsp_ready = 1;
    tick;
    chk("pop fifo_level", fifo_level, 3);
    chk("pop req_ready", req_ready, 1);
    chk("pop next strobe", write, 1);
    chk("pop next data", write_data, 32'h101);
    for (int c = 0; c < 40 && rsp_n - rbase < 5; c++) tick;
    rsp_ready = 0;
    chk("drain responses", rsp_n - rbase, 5);
    chk("drain strobes", wq.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("drain order", wq[base + i], 32'h100 + i);
    tick;

    // Back-to-back throughput.
    base = wq.size(); rbase = rsp_n;
    rsp_ready = 1; req_valid = 1; req_write = 1;
    for (int i = 0; i < 3; i++) begin
      req_data = 32'hA + i;
      chk("b2b req_ready", req_ready, 1);
      tick;
    end
    req_valid = 0;
    for (int c = 0; c < 30 && rsp_n - rbase < 3; c++) tick;
    chk("b2b responses", rsp_n - rbase, 3);
    chk("b2b strobes", wq.size() - base, 3);
    if (wq.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) chk("b2b data", wq[base + i], 32'hA + i);
      chk("b2b gap 1", wc[base + 1] - wc[base], 3);
      chk("b2b gap 2", wc[base + 2] - wc[base + 1], 3);
    end
    rsp_ready = 0;
    tick;

    // Reset while the first access waits and two more are queued.
    base = wq.size();
    req_valid = 1; req_write = 1;
    for (int i = 0; i < 3; i++) begin
      req_data = 32'h1 + i;
      tick;
    end
    req_valid = 0;
    chk("wait fifo_level", fifo_level, 2);
    chk("wait strobe seen", wq.size() - base, 1);
    chk("wait no strobe", write, 0);
    rst_n = 0;
    #1;
    chk("async rst strobes", {write, read}, 0);
    chk("async rst rsp_valid", rsp_valid, 0);
    chk("async rst fifo_level", fifo_level, 0);
    chk("async rst req_ready", req_ready, 1);
    tick; tick;
    rst_n = 1;
    base = wq.size(); rbase = rsp_n;
    rsp_ready = 1;
    for (int c = 0; c < 10; c++) tick;
    chk("post rst no strobe", wq.size() - base, 0);
    chk("post rst no rsp", rsp_n - rbase, 0);
    chk("post rst rsp_valid", rsp_valid, 0);
    chk("never write and read", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
